arb_port_mux: RTL and testbench

//  Multi-port request front end and data mux that sits directly downstream of arb_rr.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_port_mux_if.sv | 30 +++
 rtl/arb_port_buf.sv | 31 +++
 rtl/arb_port_mux.sv | 84 ++++++++
 tb/tb_arb_port_mux.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated port mux: FSM encoding and index-width helper.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Width of a port index; never below 1 so a single-port build still has a legal vector.
    function automatic int idx_w(input int n);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= n) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/arb_port_mux_if.sv
// Client-side, arbiter-side and sink-side signals of arb_port_mux bundled in one interface.
interface arb_port_mux_if #(
    parameter int PORTS_NUM = 3,
    parameter int DATA_W    = 24
);
    localparam int PW = arb_pkg::idx_w(PORTS_NUM);

    logic [PORTS_NUM-1:0]        s_valid;
    logic [PORTS_NUM-1:0]        s_ready;
    logic [PORTS_NUM*DATA_W-1:0] s_data;
    logic [PORTS_NUM-1:0]        arb_req;
    logic [PORTS_NUM-1:0]        arb_gnt;
    logic                        m_valid;
    logic                        m_ready;
    logic [DATA_W-1:0]           m_data;
    logic [PW-1:0]               m_port;

    // Environment view: clients, the arbiter and the sink.
    modport master (
        output s_valid, s_data, arb_gnt, m_ready,
        input  s_ready, arb_req, m_valid, m_data, m_port
    );

    // Mux view.
    modport slave (
        input  s_valid, s_data, arb_gnt, m_ready,
        output s_ready, arb_req, m_valid, m_data, m_port
    );

endinterface

// File: rtl/arb_port_buf.sv
// Single-entry client buffer; ready is a dedicated flop that always equals ~full.
module arb_port_buf #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              clr,
    output logic              full,
    output logic [DATA_W-1:0] word
);

    // clr only arrives while full, and capture only while empty, so the branches never overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 1'b0;
            s_ready <= 1'b1;
            word    <= '0;
        end else if (s_valid && s_ready) begin
            full    <= 1'b1;
            s_ready <= 1'b0;
            word    <= s_data;
        end else if (clr) begin
            full    <= 1'b0;
            s_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/arb_port_mux.sv
// Per-port word buffers feeding an external round-robin arbiter; the granted word is
// forwarded to one valid/ready sink and the grant is held until the sink takes it.
module arb_port_mux
    import arb_pkg::*;
#(
    parameter int PORTS_NUM = 3,
    parameter int DATA_W    = 24
) (
    input  logic          clk,
    input  logic          reset,
    arb_port_mux_if.slave bus
);

    localparam int PW = idx_w(PORTS_NUM);

    state_t                 state;
    logic [PW-1:0]          owner;
    logic [PORTS_NUM-1:0]   full;
    logic [PORTS_NUM-1:0]   clr;
    logic [PORTS_NUM-1:0]   sel;
    logic [PW-1:0]          sel_idx;
    logic                   sel_any;
    logic [DATA_W-1:0]      word [PORTS_NUM];

    for (genvar i = 0; i < PORTS_NUM; i++) begin : g_buf
        arb_port_buf #(.DATA_W(DATA_W)) u_buf (
            .clk     (clk),
            .reset   (reset),
            .s_valid (bus.s_valid[i]),
            .s_ready (bus.s_ready[i]),
            .s_data  (bus.s_data[i*DATA_W +: DATA_W]),
            .clr     (clr[i]),
            .full    (full[i]),
            .word    (word[i])
        );
        assign clr[i] = (state == ST_XFER) && bus.m_ready && (owner == PW'(i));
    end

    // Grants on empty ports are masked; a multi-hot grant falls to the lowest index.
    assign sel = bus.arb_gnt & full;

    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = PORTS_NUM - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_idx = PW'(i);
                sel_any = 1'b1;
            end
        end
    end

    // Requests drop while a word is in flight so the arbiter cannot re-grant mid-transfer.
    assign bus.arb_req = (state == ST_IDLE) ? full : '0;
    assign bus.m_port  = owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        owner       <= sel_idx;
                        bus.m_data  <= word[sel_idx];
                        bus.m_valid <= 1'b1;
                        state       <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_port_mux.sv
// Directed bench for arb_port_mux with a behavioural round-robin arbiter in the loop.
module tb_arb_port_mux;

    logic clk;
    logic reset;

    arb_port_mux_if #(.PORTS_NUM(3), .DATA_W(24)) bus ();

    arb_port_mux #(.PORTS_NUM(3), .DATA_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        sv [3];
    logic [23:0] sd [3];

    always_comb begin
        bus.s_valid = {sv[2], sv[1], sv[0]};
        bus.s_data  = {sd[2], sd[1], sd[0]};
    end

    // Round-robin arbiter model: combinational grant, pointer moves past the granted port.
    logic [1:0] last;
    logic [2:0] rr_gnt;
    int         rr_idx;
    int         j;
    logic       force_en;
    logic [2:0] force_gnt;

    always_comb begin
        rr_gnt = 3'b000;
        rr_idx = 0;
        j      = 0;
        for (int k = 1; k <= 3; k++) begin
            j = (int'(last) + k) % 3;
            if (rr_gnt == 3'b000 && bus.arb_req[j]) begin
                rr_gnt[j] = 1'b1;
                rr_idx    = j;
            end
        end
    end

    always_comb bus.arb_gnt = force_en ? force_gnt : rr_gnt;

    always @(posedge clk) begin
        if (reset) last <= 2'd2;
        else if (!force_en && rr_gnt != 3'b000) last <= rr_idx[1:0];
    end

    // Sink log: a word counts when valid & ready are seen half a cycle before the edge.
    logic [1:0]  lp [$];
    logic [23:0] ld [$];

    always @(negedge clk) begin
        if (!reset && bus.m_valid && bus.m_ready) begin
            lp.push_back(bus.m_port);
            ld.push_back(bus.m_data);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        lp.delete();
        ld.delete();
    endtask

    task automatic send(input int p, input logic [23:0] d);
        int n;
        sv[p] = 1'b1;
        sd[p] = d;
        n = 0;
        @(negedge clk);
        while (!bus.s_ready[p] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("send_ready_p%0d", p), 32'(bus.s_ready[p]), 32'd1);
        @(posedge clk);
        #1;
        sv[p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        force_en      = 1'b0;
        force_gnt     = 3'b000;
        bus.m_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0;
            sd[i] = '0;
        end

        // Reset state
        repeat (100) tick();
        @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 32'h7);
        chk("rst_arb_req", 32'(bus.arb_req), 32'h0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'h0);
        chk("rst_m_data",  32'(bus.m_data),  32'h0);
        chk("rst_m_port",  32'(bus.m_port),  32'h0);
        tick();
        reset = 1'b0;
        lp.delete();
        ld.delete();

        // Single port
        bus.m_ready = 1'b1;
        send(0, 24'h0000FF);
        n = 0;
        while (!bus.s_ready[0] && n < 4) begin
            tick();
            n++;
        end
        chk("single_s_ready", 32'(bus.s_ready[0]), 32'd1);
        chk("single_lat", 32'(n), 32'd2);
        repeat (2) tick();
        chk("single_cnt", 32'(ld.size()), 32'd1);
        if (ld.size() > 0) begin
            chk("single_data", 32'(ld[0]), 32'h0000FF);
            chk("single_port", 32'(lp[0]), 32'd0);
        end

        // Contention between ports 0 and 1
        do_reset(2);
        bus.m_ready = 1'b1;
        fork
            for (int k = 0; k < 10; k++) send(0, 24'h100000 + 24'(k));
            for (int k = 0; k < 10; k++) send(1, 24'h200000 + 24'(k));
        join
        repeat (10) tick();
        chk("cont_cnt", 32'(ld.size()), 32'd20);
        for (int i = 0; i < ld.size() && i < 20; i++) begin
            chk($sformatf("cont_port%0d", i), 32'(lp[i]), 32'(i % 2));
            chk($sformatf("cont_data%0d", i), 32'(ld[i]),
                (i % 2 == 1) ? 32'h200000 + 32'(i / 2) : 32'h100000 + 32'(i / 2));
        end

        // Backpressure with all three ports full
        do_reset(2);
        bus.m_ready = 1'b0;
        fork
            send(0, 24'hA0000A);
            send(1, 24'hB0000B);
            send(2, 24'hC0000C);
        join
        tick();
        repeat (20) begin
            @(negedge clk);
            chk("bp_hold", {bus.m_valid, bus.m_data, bus.arb_req, bus.s_ready},
                {1'b1, 24'hA0000A, 3'b000, 3'b000});
        end
        tick();
        bus.m_ready = 1'b1;
        repeat (12) tick();
        chk("bp_cnt", 32'(ld.size()), 32'd3);
        if (ld.size() == 3) begin
            chk("bp_w0", {6'd0, lp[0], ld[0]}, {8'd0, 24'hA0000A});
            chk("bp_w1", {6'd0, lp[1], ld[1]}, {8'd1, 24'hB0000B});
            chk("bp_w2", {6'd0, lp[2], ld[2]}, {8'd2, 24'hC0000C});
        end

        // Grant on an empty port is ignored; multi-hot resolves low
        do_reset(2);
        force_en    = 1'b1;
        force_gnt   = 3'b100;
        bus.m_ready = 1'b1;
        send(0, 24'h0A0A0A);
        repeat (5) tick();
        @(negedge clk);
        chk("bogus_m_valid", 32'(bus.m_valid), 32'd0);
        chk("bogus_arb_req", 32'(bus.arb_req), 32'h1);
        chk("bogus_cnt", 32'(ld.size()), 32'd0);
        tick();
        force_gnt = 3'b011;
        tick();
        @(negedge clk);
        chk("multi_win", {bus.m_valid, 5'd0, bus.m_port, bus.m_data}, {8'h80, 24'h0A0A0A});
        tick();
        force_en = 1'b0;
        repeat (3) tick();
        chk("multi_cnt", 32'(ld.size()), 32'd1);

        // Reset while a word is on the sink
        do_reset(2);
        bus.m_ready = 1'b0;
        send(1, 24'hDEAD01);
        n = 0;
        while (!bus.m_valid && n < 10) begin
            tick();
            n++;
        end
        chk("midrst_pre", 32'(bus.m_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_s_ready", 32'(bus.s_ready), 32'h7);
        bus.m_ready = 1'b1;
        repeat (10) tick();
        chk("midrst_dropped", 32'(ld.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
